// File: rtl/ula_pkg.sv
// Shared types for the sequential ULA: opcode map, FSM states and opcode width.
package ula_pkg;

    localparam int ULA_OP_W = 3;

    typedef enum logic [ULA_OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_MUL = 3'b110,
        OP_ILL = 3'b111
    } ula_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } ula_state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per cycle.
// Only built when ULA_MUL_EN is defined; otherwise the ULA has no multiplier.
// start_i loads the operands; done_o is high in the last iteration cycle, when
// product_o already carries the complete 2*WIDTH-bit product.
`ifdef ULA_MUL_EN
module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_sum;

    // The final iteration's sum is exposed directly so the result is usable
    // in the same cycle as done_o, giving exactly WIDTH busy cycles.
    assign done_o    = busy_q && (cnt_q == CNT_LAST);
    assign product_o = acc_sum;

    // One shift-add step per cycle; start overrides with fresh operands.
    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q;
        busy_d   = busy_q && !done_o;
        if (busy_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
        end
    end

    // Control state: reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath registers only move while loading or iterating.
    always_ff @(posedge clk) begin
        if (start_i || busy_q) begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule
`endif

// File: rtl/ula_n_bits_seq.sv
// Registered N-bit ULA with valid/ready handshakes on both sides.
// Build option ULA_MUL_EN: when defined, opcode 110 is a WIDTH-cycle shift-add
// multiply through ula_mul_seq; when undefined, 110 is treated as illegal.
module ula_n_bits_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                cin,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ULA_OP_W-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    s,
    output logic                cout,
    output logic                zero,
    output logic                neg,
    output logic                ovf,
    output logic                err
);

    ula_state_t        state_q, state_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    ula_op_t           op_in;
    logic              accept;
    logic              take;
    logic              take_mul;
    logic              load;

    logic [WIDTH:0]    add_w;
    logic [WIDTH:0]    sub_w;
    logic [WIDTH-1:0]  alu_s;
    logic              alu_c, alu_v, alu_e;
    logic [WIDTH-1:0]  ld_s;
    logic              ld_c, ld_v, ld_e;

    assign op_in     = ula_op_t'(op);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);

    assign s    = s_q;
    assign cout = cout_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

`ifdef ULA_MUL_EN
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_prod;

    assign take_mul  = (op_in == OP_MUL);
    assign mul_start = take && take_mul;

    ula_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign take_mul = 1'b0;
`endif

    // Single-cycle operations; anything not handled here is flagged illegal.
    // SUB borrow is the wrap bit of the (WIDTH+1)-bit difference.
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        alu_s = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_e = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_s = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_s = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_s = a & b;
            OP_OR:  alu_s = a | b;
            OP_NOT: alu_s = ~a;
            OP_XOR: alu_s = a ^ b;
            default: alu_e = 1'b1;
        endcase
    end

    // FSM next state: decides when a new op is taken and when results load.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        load    = 1'b0;
        ld_s    = alu_s;
        ld_c    = alu_c;
        ld_v    = alu_v;
        ld_e    = alu_e;
        case (state_q)
            IDLE: begin
                take = accept;
            end
`ifdef ULA_MUL_EN
            BUSY: begin
                if (mul_done) begin
                    state_d = DONE;
                    load    = 1'b1;
                    ld_s    = mul_prod[WIDTH-1:0];
                    ld_c    = |mul_prod[2*WIDTH-1:WIDTH];
                    ld_v    = 1'b0;
                    ld_e    = 1'b0;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    take = accept;
                    if (!accept) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            if (take_mul) begin
                state_d = BUSY;
            end else begin
                state_d = DONE;
                load    = 1'b1;
            end
        end
    end

    // Result registers hold until a new result loads; flags follow final s.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        if (load) begin
            s_d    = ld_s;
            cout_d = ld_c;
            zero_d = (ld_s == '0);
            neg_d  = ld_s[WIDTH-1];
            ovf_d  = ld_v;
            err_d  = ld_e;
        end
    end

    // State and result registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ula_n_bits_seq.sv
// Testbench for ula_n_bits_seq (WIDTH=8); follows ULA_MUL_EN like the design.
module tb_ula_n_bits_seq;

    localparam int W = 8;
`ifdef ULA_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          cin = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  s;
    logic          cout, zero, neg, ovf, err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         ovf;
        logic         err;
    } exp_t;

    ula_n_bits_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic [2:0] mop);
        exp_t   e;
        longint m, half, ua, ub, sa, sb, c, t, st;
        m    = longint'(1) << W;
        half = m / 2;
        ua   = longint'(ma);
        ub   = longint'(mb);
        c    = mcin ? 1 : 0;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        e    = '0;
        case (mop)
            3'd0: begin
                t      = ua + ub + c;
                e.s    = W'(t % m);
                e.cout = (t >= m);
                st     = sa + sb + c;
                e.ovf  = (st >= half) || (st < -half);
            end
            3'd1: begin
                t      = ua - ub - c;
                e.s    = W'((t + m) % m);
                e.cout = (t < 0);
                st     = sa - sb - c;
                e.ovf  = (st >= half) || (st < -half);
            end
            3'd2: e.s = ma & mb;
            3'd3: e.s = ma | mb;
            3'd4: e.s = ~ma;
            3'd5: e.s = ma ^ mb;
            3'd6: begin
                if (MUL_EN) begin
                    t      = ua * ub;
                    e.s    = W'(t % m);
                    e.cout = (t >= m);
                end else begin
                    e.err = 1'b1;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.s == '0);
        e.neg  = (longint'(e.s) >= half);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".s"},         32'(s),         32'(e.s));
        chk({tag, ".cout"},      32'(cout),      32'(e.cout));
        chk({tag, ".zero"},      32'(zero),      32'(e.zero));
        chk({tag, ".neg"},       32'(neg),       32'(e.neg));
        chk({tag, ".ovf"},       32'(ovf),       32'(e.ovf));
        chk({tag, ".err"},       32'(err),       32'(e.err));
    endtask

    // Called at a negedge with the block able to accept; returns at the
    // negedge on which the result is checked, still holding out_ready=1.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [2:0] top, input logic tcin);
        exp_t e;
        int   lat;
        e   = model(ta, tb, tcin, top);
        lat = (top == 3'd6 && MUL_EN) ? W : 0;
        out_ready = 1'b1;
        a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Garbage on the inputs must not disturb a captured operation.
        in_valid = (lat > 0);
        a = W'($urandom); b = W'($urandom); op = 3'($urandom); cin = 1'($urandom);
        for (int i = 0; i < lat; i++) begin
            #1;
            chk({tag, ".busy_in_ready"},  32'(in_ready),  32'd0);
            chk({tag, ".busy_out_valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check_result(tag, e);
    endtask

    task automatic idle_cycle(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        exp_t e;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.s",         32'(s),         32'd0);
        chk("rst.cout",      32'(cout),      32'd0);
        chk("rst.zero",      32'(zero),      32'd0);
        chk("rst.neg",       32'(neg),       32'd0);
        chk("rst.ovf",       32'(ovf),       32'd0);
        chk("rst.err",       32'(err),       32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed ALU ops, issued back-to-back
        run_op("add1",  8'b10000011, 8'b00000001, 3'd0, 1'b0);
        run_op("sub1",  8'b10010010, 8'b00000110, 3'd1, 1'b0);
        run_op("sub2",  8'b00000000, 8'b00000001, 3'd1, 1'b0);
        run_op("and",   8'b11111111, 8'b10101001, 3'd2, 1'b0);
        run_op("or",    8'b10011101, 8'b10011111, 3'd3, 1'b0);
        run_op("not",   8'b00000000, 8'hA5,       3'd4, 1'b0);
        run_op("xor",   8'hF0,       8'hFF,       3'd5, 1'b0);
        run_op("addc",  8'hFF,       8'h00,       3'd0, 1'b1);
        run_op("subov", 8'h80,       8'h01,       3'd1, 1'b0);
        run_op("subbi", 8'h80,       8'h00,       3'd1, 1'b1);
        run_op("ill",   8'h12,       8'h34,       3'd7, 1'b0);

        // Multiply (illegal when the multiplier is not built)
        run_op("mul1",  8'h10, 8'h11, 3'd6, 1'b0);
        run_op("mul2",  8'h03, 8'h05, 3'd6, 1'b0);
        run_op("mul3",  8'hFF, 8'hFF, 3'd6, 1'b0);
        idle_cycle("drain1");

        // Backpressure: result held, no new accept while out_ready=0
        a = 8'h7F; b = 8'h01; op = 3'd0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; op = 3'd2; cin = 1'b0; in_valid = 1'b1;
        e = model(8'h7F, 8'h01, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.s",         32'(s),         32'(e.s));
            chk("bp.ovf",       32'(ovf),       32'(e.ovf));
            chk("bp.in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_in_ready", 32'(in_ready), 32'd1);
        chk("bp.release_s",        32'(s),        32'(e.s));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_result("bp.next", model(8'h3C, 8'h0F, 1'b0, 3'd2));
        idle_cycle("drain2");

        // Reset with an operation in flight
        run_op("pre_rst", 8'h5A, 8'h0F, 3'd5, 1'b0);
        a = 8'h10; b = 8'h11; op = 3'd6; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef ULA_MUL_EN
        repeat (3) @(negedge clk);
`else
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.s",         32'(s),         32'd0);
        chk("mrst.cout",      32'(cout),      32'd0);
        chk("mrst.zero",      32'(zero),      32'd0);
        chk("mrst.neg",       32'(neg),       32'd0);
        chk("mrst.ovf",       32'(ovf),       32'd0);
        chk("mrst.err",       32'(err),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            #1;
            chk("mrst.no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized ops against the reference model
        for (int k = 0; k < 60; k++) begin
            run_op("rnd", W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle("rnd_idle");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_n_bits_seq.md
Name: ula_n_bits_seq

Overview:
Parametrised, registered successor to the 8-bit structural ULA. It keeps the opcode map and CIN/COUT semantics and adds a width parameter, XOR, a multi-cycle shift-add multiply and status flags. Operands and results move through valid/ready handshakes, so the block can sit in a datapath between a register file and a writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand/opcode valid.
in_ready  output  1  block can accept an operation this cycle.
cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored by other ops.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
op  input  3  opcode.
out_valid  output  1  result registers hold a valid result.
out_ready  input  1  consumer takes the result this cycle.
s  output  WIDTH  result.
cout  output  1  carry/borrow/multiply-overflow.
zero  output  1  s == 0.
neg  output  1  s[WIDTH-1].
ovf  output  1  signed overflow (ADD/SUB only, else 0).
err  output  1  illegal opcode.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; out_valid, s, cout, zero, neg, ovf, err all 0; in_ready=1 after release. Reset during BUSY abandons the multiply; no result is produced.
- Opcodes:
  - 000 ADD: s=a+b+cin; cout=carry out of bit WIDTH-1.
  - 001 SUB: s=a-b-cin; cout=borrow.
  - 010 AND.
  - 011 OR.
  - 100 NOT a (b ignored).
  - 101 XOR.
  - 110 MUL: unsigned, low WIDTH bits into s; cout=|high WIDTH bits.
  - 111 illegal: s=0, cout=0, err=1.
- ovf: for ADD, (a_msb==b_msb)&&(s_msb!=a_msb); for SUB, (a_msb!=b_msb)&&(s_msb!=a_msb).
- zero and neg are computed from the final s for every op, including illegal.
- Handshake: transfer occurs when in_valid&&in_ready; result transfer when out_valid&&out_ready. in_valid may drop without a transfer.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept single-cycle op: registers loaded at that edge → DONE; out_valid=1 the next cycle (latency 1).
  - IDLE, accept MUL → BUSY. A shift-add iteration counter runs for WIDTH cycles, then the result loads → DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - BUSY: in_ready=0; out_valid=0; inputs ignored.
  - DONE: outputs held stable while out_ready=0. With out_ready=1 and no new accept → IDLE, out_valid=0. With out_ready=1 and a same-cycle accept of a single-cycle op → stay DONE with the new result (back-to-back, one result per cycle). With out_ready=1 and a same-cycle MUL accept → BUSY.
- Operands and op are captured at accept; later input changes have no effect.
- All arithmetic wraps modulo 2^WIDTH; carry/borrow are reported only via cout.

Optional Feature:
ULA_MUL_EN.
- Defined: opcode 110 is a multi-cycle multiply as above; BUSY state and sub-module are present.
- Undefined: opcode 110 is treated as illegal (single cycle, s=0, err=1); BUSY state and multiplier are not instantiated.

Decomposition:
- Package ula_pkg holds:
  - opcode enum ula_op_t (OP_ADD..OP_ILL);
  - state enum ula_state_t (IDLE, BUSY, DONE);
  - ULA_OP_W=3.
- One sub-module, ula_mul_seq: WIDTH-parametrised shift-add multiplier with start/done, 2*WIDTH product, and an iteration counter of $clog2(WIDTH)+1 bits.

Test Plan:
1. WIDTH=8, ADD a=10000011 b=00000001 cin=0 → 1 cycle later out_valid=1, s=10000100, cout=0, ovf=0, neg=1.
2. SUB a=10010010 b=00000110 cin=0 → s=10001100, cout=0. Then SUB a=00000000 b=00000001 → s=11111111, cout=1, zero=0.
3. AND a=11111111 b=10101001 → 10101001; OR a=10011101 b=10011111 → 10011111; NOT a=00000000 → 11111111; XOR a=0xF0 b=0xFF → 0x0F. Send these back-to-back with out_ready=1: four consecutive out_valid cycles, in_ready held 1.
4. MUL (ULA_MUL_EN defined) a=0x10 b=0x11:
   - in_ready=0 for 8 cycles; out_valid at cycle 9 with s=0x10, cout=1.
   - a=3 b=5 → s=15, cout=0.
   - Without the macro: same op → s=0, err=1 after 1 cycle.
5. Backpressure: ADD 0x7F+0x01 with out_ready=0 for 5 cycles → s=0x80, ovf=1 held stable; in_ready=0; a new in_valid is not accepted until out_ready=1.
6. rst_n asserted mid-MUL (cycle 4 of BUSY) → outputs 0 immediately. After release, in_ready=1, and no stale out_valid appears.
